// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the core's single byte-laned memory port between the
// instruction-fetch requester and the load/store requester.
// Each granted request gets MEM_LATENCY cycles on the port, then one response cycle
// that carries a done pulse.
// Optional fetch starvation guard: define MEM_ARB_STARVE_GUARD_EN.
// Without it, data always has priority over fetch.
module mem_port_arbiter #(
    parameter int XLEN         = 32,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            halted,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_done,
    output logic [XLEN-1:0] if_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [XLEN-1:0] d_addr,
    input  logic [0:3][7:0] d_wdata,
    output logic            d_done,
    output logic [0:3][7:0] d_rdata,
    output logic [XLEN-1:0] mem_addr,
    output logic [0:3][7:0] mem_data_in,
    output logic            mem_write_en,
    input  logic [0:3][7:0] mem_data_out,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    // Counter load value; the first ACCESS cycle is the one where cnt still equals it.
    localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

    state_t          state;
    state_t          next_state;
    logic [3:0]      cnt;
    logic            owner_data;
    logic [XLEN-1:0] addr_q;
    logic            we_q;
    logic [0:3][7:0] wdata_q;

    logic fetch_ok;
    logic starve_force;
    logic grant_data;
    logic grant_fetch;

    // A halted core may not start new fetches.
    // Data wins unless the guard forces a pending fetch through.
    assign fetch_ok    = if_req && !halted;
    assign grant_data  = d_req && !(fetch_ok && starve_force);
    assign grant_fetch = fetch_ok && !grant_data;

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [3:0] starve_cnt;

    assign starve_force = (starve_cnt == 4'(STARVE_LIMIT));

    // Count data grants that overtook a waiting fetch; any fetch grant or fetch-free arbitration clears it
    always_ff @(posedge clk) begin
        if (rst_b) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (!fetch_ok || grant_fetch) begin
                starve_cnt <= '0;
            end else if (grant_data) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end
`else
    logic unused_starve_limit;

    assign starve_force        = 1'b0;
    assign unused_starve_limit = ^STARVE_LIMIT;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst_b) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and memory-port/handshake outputs; the port is quiet outside ACCESS
    always_comb begin
        next_state   = state;
        busy         = 1'b0;
        if_done      = 1'b0;
        d_done       = 1'b0;
        mem_addr     = '0;
        mem_data_in  = '0;
        mem_write_en = 1'b0;
        case (state)
            IDLE: begin
                if (grant_data || grant_fetch) begin
                    next_state = ACCESS;
                end
            end
            ACCESS: begin
                busy         = 1'b1;
                mem_addr     = addr_q;
                mem_write_en = we_q && (cnt == CNT_LOAD);
                if (we_q) begin
                    mem_data_in = wdata_q;
                end
                if (cnt == 4'd0) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                busy       = 1'b1;
                if_done    = !owner_data;
                d_done     = owner_data;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Latch the granted request in IDLE, count down the access, capture read data on its last cycle
    always_ff @(posedge clk) begin
        if (rst_b) begin
            cnt        <= '0;
            owner_data <= 1'b1;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_data) begin
                        owner_data <= 1'b1;
                        addr_q     <= d_addr;
                        we_q       <= d_we;
                        wdata_q    <= d_wdata;
                        cnt        <= CNT_LOAD;
                    end else if (grant_fetch) begin
                        owner_data <= 1'b0;
                        addr_q     <= if_addr;
                        we_q       <= 1'b0;
                        wdata_q    <= d_wdata;
                        cnt        <= CNT_LOAD;
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        if (owner_data) begin
                            d_rdata <= we_q ? '0 : mem_data_out;
                        end else begin
                            if_rdata <= XLEN'(mem_data_out);
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: the bench first runs a table of single transactions, applied in a loop.
// Hand-written sequences then cover back-to-back spacing, contention, halted and reset
// mid-access, plus a MEM_LATENCY=1 instance.
// Expected completions are queued when a request is driven and popped when a done pulse appears.
// Contention expectations follow MEM_ARB_STARVE_GUARD_EN when it is defined.
module tb_mem_port_arbiter;

    localparam int XLEN         = 32;
    localparam int MEM_LATENCY  = 2;
    localparam int STARVE_LIMIT = 4;

    typedef struct {
        logic        is_data;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic        is_data;
        logic [31:0] rdata;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_b;
    logic            halted;
    logic            if_req;
    logic [31:0]     if_addr;
    logic            if_done;
    logic [31:0]     if_rdata;
    logic            d_req;
    logic            d_we;
    logic [31:0]     d_addr;
    logic [0:3][7:0] d_wdata;
    logic            d_done;
    logic [0:3][7:0] d_rdata;
    logic [31:0]     mem_addr;
    logic [0:3][7:0] mem_data_in;
    logic            mem_write_en;
    logic [0:3][7:0] mem_data_out;
    logic            busy;

    logic            l1_d_req;
    logic            l1_d_we;
    logic [31:0]     l1_d_addr;
    logic [0:3][7:0] l1_d_wdata;
    logic            l1_if_done;
    logic [31:0]     l1_if_rdata;
    logic            l1_d_done;
    logic [0:3][7:0] l1_d_rdata;
    logic [31:0]     l1_mem_addr;
    logic [0:3][7:0] l1_mem_data_in;
    logic            l1_mem_write_en;
    logic [0:3][7:0] l1_mem_data_out;
    logic            l1_busy;

    logic [31:0] mem_arr [0:255];

    exp_t exp_q[$];
    vec_t vecs[8];

    int n_compared = 0;
    int n_mismatched = 0;
    int cycle = 0;
    int done_count = 0;
    int fetch_done_count = 0;
    int wen_count = 0;
    logic [31:0] last_wdata = '0;
    logic [31:0] last_waddr = '0;

    mem_port_arbiter #(
        .XLEN(XLEN), .MEM_LATENCY(MEM_LATENCY), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .rst_b(rst_b), .halted(halted),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_write_en(mem_write_en),
        .mem_data_out(mem_data_out), .busy(busy)
    );

    mem_port_arbiter #(
        .XLEN(XLEN), .MEM_LATENCY(1), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut_l1 (
        .clk(clk), .rst_b(rst_b), .halted(1'b0),
        .if_req(1'b0), .if_addr(32'h0), .if_done(l1_if_done), .if_rdata(l1_if_rdata),
        .d_req(l1_d_req), .d_we(l1_d_we), .d_addr(l1_d_addr), .d_wdata(l1_d_wdata),
        .d_done(l1_d_done), .d_rdata(l1_d_rdata),
        .mem_addr(l1_mem_addr), .mem_data_in(l1_mem_data_in), .mem_write_en(l1_mem_write_en),
        .mem_data_out(l1_mem_data_out), .busy(l1_busy)
    );

    assign l1_mem_data_out = 32'h5A5AA5A5;
    assign mem_data_out    = mem_arr[mem_addr[9:2]];

    always #5 clk = ~clk;

    // Word memory behind the main port; reset reloads the known words
    always @(posedge clk) begin
        if (rst_b) begin
            mem_arr[16] <= 32'h12345678;
            mem_arr[17] <= 32'h0BADBEEF;
            mem_arr[32] <= 32'hCAFEF00D;
            mem_arr[64] <= 32'h00000000;
        end else if (mem_write_en) begin
            mem_arr[mem_addr[9:2]] <= mem_data_in;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
        end
    endtask

    task automatic pushExp(input logic is_data, input logic [31:0] rdata);
        exp_t e;
        e.is_data = is_data;
        e.rdata   = rdata;
        exp_q.push_back(e);
    endtask

    // One cycle: sample at negedge, log writes, score any done pulse
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cycle++;
        if (mem_write_en) begin
            wen_count++;
            last_wdata = mem_data_in;
            last_waddr = mem_addr;
        end
        if (if_done || d_done) begin
            done_count++;
            if (if_done) fetch_done_count++;
            checkOutput("done_exclusive", 32'(if_done & d_done), 32'd0);
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_done", {30'b0, if_done, d_done}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("done_owner", {31'b0, d_done}, {31'b0, e.is_data});
                checkOutput("rdata", d_done ? d_rdata : if_rdata, e.rdata);
            end
        end
    endtask

    task automatic waitDone(input string name);
        int target;
        target = done_count + 1;
        for (int i = 0; i < 40 && done_count < target; i++) tick();
        checkOutput(name, 32'(done_count >= target), 32'd1);
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 40 && busy; i++) tick();
        tick();
        checkOutput("idle_reached", {31'b0, busy}, 32'd0);
    endtask

    task automatic applyStimulus(input vec_t v);
        int start;
        int wen0;
        waitIdle();
        start = cycle;
        wen0  = wen_count;
        if (v.is_data) begin
            d_req   = 1'b1;
            d_we    = v.we;
            d_addr  = v.addr;
            d_wdata = v.wdata;
        end else begin
            if_req  = 1'b1;
            if_addr = v.addr;
        end
        pushExp(v.is_data, v.exp_rdata);
        waitDone("vec_done");
        checkOutput("latency", 32'(cycle - start), 32'(MEM_LATENCY + 1));
        if_req = 1'b0;
        d_req  = 1'b0;
        checkOutput("write_count", 32'(wen_count - wen0), v.we ? 32'd1 : 32'd0);
        if (v.we) begin
            checkOutput("write_data", last_wdata, v.wdata);
            checkOutput("write_addr", last_waddr, v.addr);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_if_done"}, {31'b0, if_done}, 32'd0);
        checkOutput({tag, "_d_done"}, {31'b0, d_done}, 32'd0);
        checkOutput({tag, "_if_rdata"}, if_rdata, 32'd0);
        checkOutput({tag, "_d_rdata"}, d_rdata, 32'd0);
        checkOutput({tag, "_mem_addr"}, mem_addr, 32'd0);
        checkOutput({tag, "_mem_data_in"}, mem_data_in, 32'd0);
        checkOutput({tag, "_mem_write_en"}, {31'b0, mem_write_en}, 32'd0);
        checkOutput({tag, "_busy"}, {31'b0, busy}, 32'd0);
    endtask

    // Hard stop in case something upstream hangs
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: actual=time_limit required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence
    initial begin
        int c1;
        int c2;
        int f0;
        int d0;
        logic is_d;

        vecs[0] = '{1'b0, 1'b0, 32'h40,  32'h0,        32'h12345678};
        vecs[1] = '{1'b1, 1'b0, 32'h44,  32'h0,        32'h0BADBEEF};
        vecs[2] = '{1'b0, 1'b0, 32'h80,  32'h0,        32'hCAFEF00D};
        vecs[3] = '{1'b1, 1'b1, 32'h100, 32'hAABBCCDD, 32'h00000000};
        vecs[4] = '{1'b1, 1'b0, 32'h100, 32'h0,        32'hAABBCCDD};
        vecs[5] = '{1'b1, 1'b1, 32'h44,  32'h11223344, 32'h00000000};
        vecs[6] = '{1'b0, 1'b0, 32'h44,  32'h0,        32'h11223344};
        vecs[7] = '{1'b1, 1'b0, 32'h40,  32'h0,        32'h12345678};

        rst_b = 1'b1; halted = 1'b0; if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        l1_d_req = 1'b0; l1_d_we = 1'b0; l1_d_addr = '0; l1_d_wdata = '0;
        tick();
        tick();
        checkAllZero("reset");
        rst_b = 1'b0;

        for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

        // Store then load held back-to-back: done pulses MEM_LATENCY+2 apart
        waitIdle();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'h01020304;
        pushExp(1'b1, 32'h0);
        pushExp(1'b1, 32'h01020304);
        waitDone("b2b_store_done");
        c1 = cycle;
        d_we = 1'b0;
        waitDone("b2b_load_done");
        c2 = cycle;
        d_req = 1'b0;
        checkOutput("done_spacing", 32'(c2 - c1), 32'(MEM_LATENCY + 2));

        // Both requesters held continuously
        waitIdle();
        f0 = fetch_done_count;
        if_addr = 32'h80; d_addr = 32'h40; d_we = 1'b0;
        if_req = 1'b1; d_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
            is_d = ((i % (STARVE_LIMIT + 1)) != STARVE_LIMIT);
`else
            is_d = 1'b1;
`endif
            pushExp(is_d, is_d ? 32'h12345678 : 32'hCAFEF00D);
        end
        for (int i = 0; i < 10; i++) waitDone("contend_done");
        if_req = 1'b0; d_req = 1'b0;
`ifdef MEM_ARB_STARVE_GUARD_EN
        checkOutput("contend_fetches", 32'(fetch_done_count - f0), 32'd2);
`else
        checkOutput("contend_fetches", 32'(fetch_done_count - f0), 32'd0);
`endif

        // Halted blocks the fetch; halting during an in-flight fetch does not
        waitIdle();
        halted = 1'b1; if_req = 1'b1; if_addr = 32'h40;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("halted_busy", {31'b0, busy}, 32'd0);
        end
        halted = 1'b0;
        pushExp(1'b0, 32'h12345678);
        tick();
        checkOutput("fetch_started", {31'b0, busy}, 32'd1);
        halted = 1'b1;
        waitDone("halted_fetch_done");
        if_req = 1'b0; halted = 1'b0;

        // Reset in the second ACCESS cycle of a load aborts it silently
        waitIdle();
        d0 = done_count;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44;
        tick();
        tick();
        checkOutput("abort_in_access", {31'b0, busy}, 32'd1);
        rst_b = 1'b1; d_req = 1'b0;
        tick();
        checkAllZero("abort");
        rst_b = 1'b0;
        tick();
        tick();
        checkOutput("abort_no_done", 32'(done_count - d0), 32'd0);
        applyStimulus('{1'b1, 1'b0, 32'h44, 32'h0, 32'h0BADBEEF});

        // MEM_LATENCY=1 instance: store then load held back-to-back
        l1_d_req = 1'b1; l1_d_we = 1'b1; l1_d_addr = 32'h10; l1_d_wdata = 32'hDEADBEEF;
        tick();
        checkOutput("l1_write_en", {31'b0, l1_mem_write_en}, 32'd1);
        checkOutput("l1_write_data", l1_mem_data_in, 32'hDEADBEEF);
        checkOutput("l1_write_addr", l1_mem_addr, 32'h10);
        checkOutput("l1_no_early_done", {31'b0, l1_d_done}, 32'd0);
        tick();
        checkOutput("l1_store_done", {31'b0, l1_d_done}, 32'd1);
        checkOutput("l1_write_en_off", {31'b0, l1_mem_write_en}, 32'd0);
        checkOutput("l1_store_rdata", l1_d_rdata, 32'd0);
        l1_d_we = 1'b0;
        tick();
        checkOutput("l1_idle_gap", {31'b0, l1_busy}, 32'd0);
        tick();
        checkOutput("l1_load_no_write", {31'b0, l1_mem_write_en}, 32'd0);
        tick();
        checkOutput("l1_load_done", {31'b0, l1_d_done}, 32'd1);
        checkOutput("l1_load_rdata", l1_d_rdata, 32'h5A5AA5A5);
        l1_d_req = 1'b0;
        tick();
        tick();

        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Multi-cycle arbiter and sequencer that shares the core's single 32-bit, byte-laned memory port between the instruction-fetch requester and the load/store requester. It latches one request at a time, drives the memory for a fixed access latency, and returns read data with a one-cycle completion pulse. It sits between `data_path` (fetch and data requesters) and the external memory interface of `mips_core`.

## Interface
- `XLEN`, 32, address/data width
- `MEM_LATENCY`, 2, memory cycles per access (legal range 1–15)
- `STARVE_LIMIT`, 4, consecutive data grants tolerated while a fetch is pending (legal range 1–15)

- `clk`  in  1  clock
- `rst_b`  in  1  reset; synchronous, active-high
- `halted`  in  1  core halted; blocks new fetch grants
- `if_req`  in  1  fetch request, level, held until `if_done`
- `if_addr`  in  XLEN  fetch address
- `if_done`  out  1  one-cycle completion pulse for fetch
- `if_rdata`  out  XLEN  fetched word, valid while `if_done`=1
- `d_req`  in  1  data request, level, held until `d_done`
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  XLEN  data address
- `d_wdata`  in  8 x [0:3]  store bytes
- `d_done`  out  1  one-cycle completion pulse for data
- `d_rdata`  out  8 x [0:3]  load bytes, valid while `d_done`=1
- `mem_addr`  out  XLEN  memory address
- `mem_data_in`  out  8 x [0:3]  bytes written to memory
- `mem_write_en`  out  1  memory write strobe
- `mem_data_out`  in  8 x [0:3]  bytes read from memory
- `busy`  out  1  1 in any state other than IDLE

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: grant is evaluated from `d_req` and `if_req`, where `if_req` counts only when `halted`=0.
  - Data has priority over fetch (starvation guard aside).
  - On a grant, the block latches owner, address, `d_we` and `d_wdata`, loads `cnt` = MEM_LATENCY-1, and moves to ACCESS.
  - With no qualifying request, it stays in IDLE.
- ACCESS: `mem_addr` = latched address.
  - `mem_data_in` = latched wdata for stores, 0 otherwise.
  - `mem_write_en` = 1 only in the first ACCESS cycle of a store.
  - `cnt` decrements each cycle.
  - When `cnt`=0, the block captures `mem_data_out` into the owner's rdata register and moves to RESP.
- RESP: the owner's `*_done` = 1 for exactly one cycle, then the FSM returns to IDLE.
  - For stores, `d_rdata` = 0.
- Requester contract: drop `req` on the edge at which `done`=1. `req` still high in the next IDLE cycle is a new request.
- Inputs are sampled only in IDLE. Address or data changes during ACCESS/RESP have no effect.
- `halted` rising during an in-flight fetch does not abort it; that fetch completes normally.
- Rdata registers hold their last value between completions.

## Timing
- Reset (`rst_b`=1 at edge): state=IDLE, `cnt`=0, owner=data, starvation counter=0.
  - All outputs 0: `if_done`, `d_done`, `if_rdata`, `d_rdata`, `mem_addr`, `mem_data_in`, `mem_write_en`, `busy`.
- Reset mid-access aborts the access with no `done` pulse. A store aborted after its first ACCESS cycle has already been written.
- Request-to-done latency: `req` sampled high in IDLE at edge N gives ACCESS in cycles N+1..N+MEM_LATENCY and `done` in cycle N+MEM_LATENCY+1.
- Throughput: one access per MEM_LATENCY+2 cycles. IDLE always lasts at least one cycle between accesses.
- Simultaneous `if_req` and `d_req` in IDLE: data wins unless the starvation guard forces fetch. The losing request stays pending, and no pulse is issued for it.
- MEM_LATENCY=1: ACCESS lasts one cycle, during which `mem_write_en` and the data capture coincide.

## Configuration
- `MEM_ARB_STARVE_GUARD_EN` defined:
  - A 4-bit counter increments on each data grant made while a qualifying fetch is pending.
  - It clears on any fetch grant, and on any IDLE arbitration with no qualifying fetch.
  - When the counter equals STARVE_LIMIT, the next arbitration with both requests pending grants fetch.
- Not defined: strict data priority. STARVE_LIMIT is ignored and no counter is built.

## Test plan
- Reset, then fetch only: `if_req`=1, `if_addr`=0x40, mem returns 0x12345678 → `if_done` in cycle MEM_LATENCY+1 (3 with default) after sampling, `if_rdata`=0x12345678, `mem_write_en` never 1.
- Store, then load at 0x100, bytes {AA,BB,CC,DD} → `mem_write_en` high exactly 1 cycle with `mem_data_in`={AA,BB,CC,DD}; the following load gets `d_rdata`={AA,BB,CC,DD}; the two `d_done` pulses are 4 cycles apart.
- `if_req` and `d_req` both held continuously, guard defined, STARVE_LIMIT=4 → grant sequence D,D,D,D,F repeating. Guard undefined → D only, `if_done` never pulses.
- `halted`=1 with `if_req`=1 → no grant and `busy`=0. `halted` raised mid-fetch → that fetch still delivers `if_done`.
- `rst_b` asserted in the second ACCESS cycle of a load → next cycle all outputs 0, no `d_done`. Request re-issued after reset completes normally.
- MEM_LATENCY=1: store → `mem_write_en` for 1 cycle, `d_done` 2 cycles after sampling.
